// File: rtl/motion_detect_pkg.sv
// rtl/motion_detect_pkg.sv - shared states, channels and default geometry for the motion-detect sequencer
package motion_detect_pkg;

  localparam int FRAME_WORDS_DEF = 331776;
  localparam int ADDR_W_DEF      = 20;
  localparam int BG_BASE_DEF     = 0;
  localparam int FR_BASE_DEF     = 331776;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic {
    CH_BG,
    CH_FR
  } chan_t;

endpackage

// File: rtl/motion_detect_drain.sv
// rtl/motion_detect_drain.sv - highlight fifo to valid/ready result stream with handshake counter
module motion_detect_drain #(
  parameter int FRAME_WORDS = 8,
  parameter int CW          = $clog2(FRAME_WORDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          clear,
  input  logic          hl_empty,
  output logic          hl_rd_en,
  input  logic [31:0]   hl_dout,
  output logic          res_valid,
  output logic [31:0]   res_data,
  input  logic          res_ready,
  output logic          drain_fin
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS);

  logic [CW-1:0] rd_cnt, drain_cnt, drain_cnt_nxt;
  logic          pend, issue, hs;

  // Only one read in flight, and only when the output slot is certain to be free at load time.
  always_comb begin
    hs            = res_valid && res_ready;
    issue         = run && !hl_empty && (rd_cnt < LAST) && !hl_rd_en && !pend &&
                    (!res_valid || res_ready);
    drain_cnt_nxt = drain_cnt + (hs ? CW'(1) : CW'(0));
    drain_fin     = (drain_cnt_nxt == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hl_rd_en  <= 1'b0;
      pend      <= 1'b0;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      hl_rd_en <= issue;
      pend     <= hl_rd_en;
      if (clear) begin
        rd_cnt    <= '0;
        drain_cnt <= '0;
      end else begin
        rd_cnt    <= rd_cnt + (issue ? CW'(1) : CW'(0));
        drain_cnt <= drain_cnt_nxt;
      end
      if (pend) begin
        res_data  <= hl_dout;
        res_valid <= 1'b1;
      end else if (hs) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/motion_detect_seq.sv
// rtl/motion_detect_seq.sv - frame sequencer: alternating bg/fr memory loads plus concurrent result drain
module motion_detect_seq
  import motion_detect_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BG_BASE     = BG_BASE_DEF,
  parameter int FR_BASE     = FR_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              bg_full,
  output logic              bg_wr_en,
  output logic [31:0]       bg_din,
  input  logic              fr_full,
  output logic              fr_wr_en,
  output logic [31:0]       fr_din,
  input  logic              fr_hl_full,
  output logic              fr_hl_wr_en,
  output logic [31:0]       fr_hl_din,
  input  logic              hl_empty,
  output logic              hl_rd_en,
  input  logic [31:0]       hl_dout,
  output logic              res_valid,
  output logic [31:0]       res_data,
  input  logic              res_ready
);

  localparam int            CW   = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS);

  state_t        state, state_nxt;
  chan_t         ptr, rd_chan;
  logic [CW-1:0] bg_cnt, fr_cnt;
  logic          pend_bg, pend_fr;
  logic          run, enter_run, drain_fin;
  logic          bg_elig, fr_elig, grant_bg, grant_fr;

  // A channel never reads two cycles running, so its fifo always has room for the in-flight word.
  always_comb begin
    run       = (state == ST_RUN);
    enter_run = (state == ST_IDLE) && start;
    bg_elig   = run && (bg_cnt < LAST) && !bg_full && !(mem_rd_en && rd_chan == CH_BG);
    fr_elig   = run && (fr_cnt < LAST) && !fr_full && !fr_hl_full &&
                !(mem_rd_en && rd_chan == CH_FR);
    grant_bg  = bg_elig && (!fr_elig || ptr == CH_BG);
    grant_fr  = fr_elig && !grant_bg;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if ((bg_cnt == LAST) && (fr_cnt == LAST) && !mem_rd_en && !pend_bg &&
                   !pend_fr && drain_fin) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      rd_chan     <= CH_BG;
      ptr         <= CH_BG;
      bg_cnt      <= '0;
      fr_cnt      <= '0;
      pend_bg     <= 1'b0;
      pend_fr     <= 1'b0;
      bg_wr_en    <= 1'b0;
      bg_din      <= '0;
      fr_wr_en    <= 1'b0;
      fr_din      <= '0;
      fr_hl_wr_en <= 1'b0;
      fr_hl_din   <= '0;
    end else begin
      busy      <= (state_nxt == ST_RUN);
      done      <= (state_nxt == ST_DONE);
      mem_rd_en <= grant_bg || grant_fr;
      if (grant_bg)      mem_addr <= ADDR_W'(BG_BASE) + ADDR_W'(bg_cnt);
      else if (grant_fr) mem_addr <= ADDR_W'(FR_BASE) + ADDR_W'(fr_cnt);
      if (grant_fr)      rd_chan <= CH_FR;
      else if (grant_bg) rd_chan <= CH_BG;
      pend_bg     <= mem_rd_en && (rd_chan == CH_BG);
      pend_fr     <= mem_rd_en && (rd_chan == CH_FR);
      bg_wr_en    <= pend_bg;
      fr_wr_en    <= pend_fr;
      fr_hl_wr_en <= pend_fr;
      if (pend_bg) bg_din <= mem_rdata;
      if (pend_fr) begin
        fr_din    <= mem_rdata;
        fr_hl_din <= mem_rdata;
      end
      if (enter_run) begin
        bg_cnt <= '0;
        fr_cnt <= '0;
        ptr    <= CH_BG;
      end else begin
        if (grant_bg) bg_cnt <= bg_cnt + CW'(1);
        if (grant_fr) fr_cnt <= fr_cnt + CW'(1);
        if (bg_elig && fr_elig) ptr <= (ptr == CH_BG) ? CH_FR : CH_BG;
      end
    end
  end

  motion_detect_drain #(
    .FRAME_WORDS(FRAME_WORDS),
    .CW         (CW)
  ) u_drain (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .clear    (enter_run),
    .hl_empty (hl_empty),
    .hl_rd_en (hl_rd_en),
    .hl_dout  (hl_dout),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_ready(res_ready),
    .drain_fin(drain_fin)
  );

endmodule

// File: tb/tb_motion_detect_seq.sv
// tb/tb_motion_detect_seq.sv - scoreboard bench for motion_detect_seq with memory and highlight fifo models
module tb_motion_detect_seq;

  localparam int FW  = 8;
  localparam int AW  = 20;
  localparam int BGB = 16;
  localparam int FRB = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          bg_full = 1'b0, fr_full = 1'b0, fr_hl_full = 1'b0;
  logic          bg_wr_en, fr_wr_en, fr_hl_wr_en, hl_rd_en, res_valid;
  logic [31:0]   bg_din, fr_din, fr_hl_din, res_data;
  logic          hl_empty = 1'b1;
  logic [31:0]   hl_dout = '0;
  logic          res_ready = 1'b1;

  always #5 clk = ~clk;

  motion_detect_seq #(
    .FRAME_WORDS(FW),
    .ADDR_W     (AW),
    .BG_BASE    (BGB),
    .FR_BASE    (FRB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .bg_full    (bg_full),
    .bg_wr_en   (bg_wr_en),
    .bg_din     (bg_din),
    .fr_full    (fr_full),
    .fr_wr_en   (fr_wr_en),
    .fr_din     (fr_din),
    .fr_hl_full (fr_hl_full),
    .fr_hl_wr_en(fr_hl_wr_en),
    .fr_hl_din  (fr_hl_din),
    .hl_empty   (hl_empty),
    .hl_rd_en   (hl_rd_en),
    .hl_dout    (hl_dout),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready)
  );

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  int          bg_rd_seen = 0;
  bit          mon_en = 1'b0;
  bit          rr_rand = 1'b0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_bg[$];
  logic [31:0] exp_fr[$];
  logic [31:0] exp_res[$];
  logic [31:0] hl_q[$];

  function automatic logic [31:0] mem_word(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_word(int'(mem_addr));

  always @(posedge clk) begin
    if (hl_rd_en && hl_q.size() > 0) hl_dout <= hl_q.pop_front();
    hl_empty <= (hl_q.size() == 0);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples on the falling edge, pops expectations as the DUT presents outputs.
  logic        is_bg_rd, prev_bg_rd = 1'b0, prev_fr_rd = 1'b0;
  logic        bg_full_d = 1'b0, fr_block_d = 1'b0, stall_d = 1'b0;
  logic [31:0] res_data_d = '0;

  always @(negedge clk) begin
    is_bg_rd = (int'(mem_addr) >= BGB) && (int'(mem_addr) < BGB + FW);
    if (mon_en) begin
      if (mem_rd_en) begin
        if (exp_addr.size() > 0) check("rd_order", 32'(mem_addr), exp_addr.pop_front());
        if (is_bg_rd) begin
          check("bg_rd_gap", 32'(prev_bg_rd), 0);
          check("bg_rd_while_full", 32'(bg_full_d), 0);
          bg_rd_seen++;
        end else begin
          check("fr_rd_gap", 32'(prev_fr_rd), 0);
          check("fr_rd_while_full", 32'(fr_block_d), 0);
        end
      end
      if (bg_wr_en) begin
        check("bg_wr_expected", 32'(exp_bg.size() != 0), 1);
        if (exp_bg.size() != 0) check("bg_din", bg_din, exp_bg.pop_front());
      end
      if (fr_wr_en || fr_hl_wr_en) begin
        check("fr_wr_pair", 32'(fr_hl_wr_en), 32'(fr_wr_en));
        check("fr_hl_din", fr_hl_din, fr_din);
        check("fr_wr_expected", 32'(exp_fr.size() != 0), 1);
        if (exp_fr.size() != 0) check("fr_din", fr_din, exp_fr.pop_front());
      end
      if (stall_d) begin
        check("res_hold_valid", 32'(res_valid), 1);
        check("res_hold_data", res_data, res_data_d);
      end
      if (res_valid && res_ready) begin
        check("res_expected", 32'(exp_res.size() != 0), 1);
        if (exp_res.size() != 0) check("res_data", res_data, exp_res.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("done_busy_excl", 32'(busy), 0);
      end
    end
    prev_bg_rd = mem_rd_en && is_bg_rd;
    prev_fr_rd = mem_rd_en && !is_bg_rd;
    bg_full_d  = bg_full;
    fr_block_d = fr_full || fr_hl_full;
    stall_d    = res_valid && !res_ready;
    res_data_d = res_data;
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic begin_frame(input logic [31:0] base, input bit ord);
    for (int i = 0; i < FW; i++) begin
      if (ord) begin
        exp_addr.push_back(32'(BGB + i));
        exp_addr.push_back(32'(FRB + i));
      end
      exp_bg.push_back(mem_word(BGB + i));
      exp_fr.push_back(mem_word(FRB + i));
      hl_q.push_back(base + 32'(i + 1));
      exp_res.push_back(base + 32'(i + 1));
    end
    done_base  = done_cnt;
    bg_rd_seen = 0;
    pulse_start();
    @(negedge clk);
    check("busy_in_run", 32'(busy), 1);
  endtask

  task automatic finish_frame(input string name, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_done_in_time"}, 32'(n < budget), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({name, "_done_once"}, 32'(done_cnt - done_base), 1);
    check({name, "_bg_left"}, 32'(exp_bg.size()), 0);
    check({name, "_fr_left"}, 32'(exp_fr.size()), 0);
    check({name, "_res_left"}, 32'(exp_res.size()), 0);
    check({name, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {24'd0, busy, done, mem_rd_en, bg_wr_en, fr_wr_en, fr_hl_wr_en,
                          hl_rd_en, res_valid}, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_bg_din", bg_din, 0);
    check("rst_fr_din", fr_din | fr_hl_din, 0);
    check("rst_res_data", res_data, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;

    begin_frame(32'h0000_0100, 1'b1);
    finish_frame("basic", 300);

    begin_frame(32'h0000_0200, 1'b0);
    repeat (3) @(posedge clk);
    #1 bg_full = 1'b1;
    repeat (20) @(posedge clk);
    #1 bg_full = 1'b0;
    finish_frame("bg_full", 400);

    begin_frame(32'h0000_0300, 1'b0);
    repeat (2) @(posedge clk);
    #1 fr_hl_full = 1'b1;
    repeat (12) @(posedge clk);
    #1 fr_hl_full = 1'b0;
    finish_frame("fr_hl_full", 400);

    rr_rand = 1'b1;
    begin_frame(32'h0000_0000, 1'b0);
    finish_frame("res_stall", 1000);
    rr_rand = 1'b0;

    begin_frame(32'h0000_0500, 1'b0);
    begin
      int n = 0;
      while (bg_rd_seen < 3 && n < 100) begin
        @(posedge clk);
        n++;
      end
      check("abort_bg3_reached", 32'(n < 100), 1);
    end
    #1 reset = 1'b0;
    mon_en = 1'b0;
    #1;
    check("abort_strobes", {24'd0, busy, done, mem_rd_en, bg_wr_en, fr_wr_en, fr_hl_wr_en,
                            hl_rd_en, res_valid}, 0);
    check("abort_mem_addr", 32'(mem_addr), 0);
    exp_addr.delete();
    exp_bg.delete();
    exp_fr.delete();
    exp_res.delete();
    hl_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;
    begin_frame(32'h0000_0600, 1'b1);
    finish_frame("restart", 300);

    begin_frame(32'h0000_0700, 1'b0);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_frame("start_in_run", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/motion_detect_seq.md
MOTION_DETECT_SEQ -- requirements
Module: motion_detect_seq

Interface
REQ-001 Parameters (name, default, meaning): FRAME_WORDS, 331776, 32-bit pixel words per frame (BMP header excluded); ADDR_W, 20, frame-memory word-address width; BG_BASE, 0, background frame word base; FR_BASE, 331776, pedestrian frame word base.
REQ-002 Ports (name direction width meaning): clk in 1 clock; reset in 1 asynchronous active-low reset; start in 1 begin-frame pulse; busy out 1 frame in progress; done out 1 one-cycle completion pulse.
REQ-003 Memory ports: mem_rd_en out 1 read strobe; mem_addr out ADDR_W word address; mem_rdata in 32 data valid the cycle after mem_rd_en.
REQ-004 FIFO ports: bg_full in 1; bg_wr_en out 1; bg_din out 32; fr_full in 1; fr_wr_en out 1; fr_din out 32; fr_hl_full in 1; fr_hl_wr_en out 1; fr_hl_din out 32; hl_empty in 1; hl_rd_en out 1; hl_dout in 32, valid the cycle after hl_rd_en.
REQ-005 Result stream: res_valid out 1; res_data out 32; res_ready in 1.

Function
REQ-006 The block SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when all three counters reach FRAME_WORDS, DONE->IDLE unconditionally after one cycle.
REQ-007 start in RUN or DONE SHALL be ignored; busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-008 Entering RUN SHALL clear bg_cnt, fr_cnt, drain_cnt (each clog2(FRAME_WORDS+1) bits) and the arbiter pointer (initially BG).
REQ-009 BG channel eligible: RUN, bg_cnt issued < FRAME_WORDS, !bg_full, no BG read issued in the previous cycle.
REQ-010 FR channel eligible: RUN, fr_cnt issued < FRAME_WORDS, !fr_full, !fr_hl_full, no FR read issued in the previous cycle.
REQ-011 At most one mem read per cycle; if both eligible, grant pointer's channel, then toggle pointer; if one eligible, grant it and leave pointer unchanged.
REQ-012 Granted BG read: mem_addr = BG_BASE + bg_cnt; granted FR read: mem_addr = FR_BASE + fr_cnt; counter increments in the grant cycle.
REQ-013 One cycle after a BG grant, bg_wr_en=1, bg_din=mem_rdata; after an FR grant, fr_wr_en=fr_hl_wr_en=1 in the same cycle with fr_din=fr_hl_din=mem_rdata.
REQ-014 Drain engine runs concurrently with loading throughout RUN: hl_rd_en=1 when RUN, !hl_empty, drain_cnt issued < FRAME_WORDS, no read in flight, and res_valid=0 or res_ready=1.
REQ-015 Cycle after hl_rd_en, res_data SHALL load hl_dout and res_valid SHALL set; res_valid clears on res_valid&&res_ready with no new load; res_data held stable while res_valid&&!res_ready.
REQ-016 drain_cnt SHALL count completed res handshakes; DONE is entered the cycle after the final handshake and after the final FIFO write.
REQ-017 Full flag asserting with a read in flight SHALL NOT drop the in-flight write (alternation rule guarantees a free slot).
REQ-018 All outputs SHALL be registered; write/read strobes SHALL be 0 outside RUN except a trailing write of an in-flight read.

Reset
REQ-019 reset low SHALL asynchronously force IDLE, all counters 0, pointer BG, and busy, done, mem_rd_en, all wr_en/rd_en, res_valid to 0; mem_addr, *_din, res_data to 0.
REQ-020 reset asserted mid-RUN SHALL abandon the frame; in-flight read data SHALL be discarded; the next start restarts from word 0.

Structure
REQ-021 A shared package motion_detect_pkg SHALL hold the state enum, channel enum (BG, FR), and FRAME_WORDS/base-address constants.
REQ-022 The drain engine SHALL be sub-module motion_detect_drain (fifo-to-valid/ready adapter with word counter); arbitration and state machine remain in the top.

Verification
REQ-023 FRAME_WORDS=8, all FIFOs never full, res_ready=1: mem reads alternate BG0,FR0,BG1,FR1...; 8 writes each to bg/fr/fr_hl; done pulses once.
REQ-024 bg_full held 1 for 20 cycles: only FR reads at most every other cycle; BG resumes at address BG_BASE+bg_cnt with no word lost or duplicated.
REQ-025 fr_hl_full=1 while fr_full=0: no FR grant; fr_wr_en and fr_hl_wr_en always coincide.
REQ-026 res_ready toggled 0/1 randomly, hl FIFO preloaded 0x1..0x8: res_data sequence exactly 0x1..0x8, each held while stalled.
REQ-027 reset low mid-frame at bg_cnt=3: all strobes 0 immediately; new start issues address BG_BASE+0.
REQ-028 start pulsed during RUN: no counter reset, single done at frame end.
